osd_vram_wr_bridge: RTL and testbench
=====================================

Name: osd_vram_wr_bridge

Overview:
Parametrised CPU-to-VRAM write bridge for the OSD character generator. It replaces direct level-driven VRAM writes from the CPU register bus. CPU strobes are edge-detected, tagged with an auto-incrementing address pointer and buffered in a FIFO. Entries are drained to the VRAM write port, optionally only during video blanking, so the display never tears. It sits between the CPU io register block and the character generator's VRAM write port, in the NFSC_CK domain.

Parameters:
C_AW, 10, VRAM address width; pointer wraps mod 2^C_AW
C_DW, 8, VRAM data width
C_FIFO_DEPTH, 16, FIFO entries; power of 2, >=2
C_GATE_BLANK, 1, 1 = drain only while BLANK_i=1; 0 = drain whenever FIFO is non-empty

Ports:
CK_i  in  1  clock (NFSC_CK domain)
XSYS_R_i  in  1  synchronous active-low reset
REG_ADDR_LD_i  in  1  level; while 1, address pointer loads REG_ADDRs_i
REG_ADDRs_i  in  C_AW  pointer load value
REG_WDs_i  in  C_DW  write data captured on strobe edge
REG_WR_STB_i  in  1  CPU write strobe (register bit); rising edge = one write
REG_AUTO_INC_i  in  1  1 = pointer +1 after each accepted push
BLANK_i  in  1  video blanking from the sync generator
FLUSH_i  in  1  level; clears FIFO and overflow flag
VRAM_WE_o  out  1  one-cycle VRAM write enable
VRAM_WAs_o  out  C_AW  VRAM write address
VRAM_WDs_o  out  C_DW  VRAM write data
ADDR_PTRs_o  out  C_AW  current address pointer
FIFO_LEVELs_o  out  log2(C_FIFO_DEPTH)+1  occupied entries
FULL_o  out  1  level == C_FIFO_DEPTH
EMPTY_o  out  1  level == 0
OVF_o  out  1  sticky; set when a push is dropped because FIFO is full

Behaviour:
- All state changes occur on the CK_i rising edge. Reset is synchronous, XSYS_R_i=0.
- Reset values:
  - VRAM_WE_o=0, VRAM_WAs_o=0, VRAM_WDs_o=0.
  - ADDR_PTRs_o=0, FIFO_LEVELs_o=0, EMPTY_o=1, FULL_o=0, OVF_o=0.
  - Strobe delay register STB_D resets to 1, so a strobe held high through reset release does not push. It must go low first.
- Edge detect: PUSH_REQ = REG_WR_STB_i & ~STB_D. STB_D <= REG_WR_STB_i every cycle.
- Push:
  - Accepted when PUSH_REQ=1, FULL_o=0 (registered value) and FLUSH_i=0.
  - Entry = {A, REG_WDs_i}. A = REG_ADDRs_i if REG_ADDR_LD_i=1, else ADDR_PTRs_o.
- Pointer update:
  - If LD: ptr <= REG_ADDRs_i + (accepted push & AUTO_INC).
  - Else if accepted push & AUTO_INC: ptr <= ptr+1, wrapping 2^C_AW-1 -> 0.
  - Otherwise hold.
  - FLUSH_i does not affect the pointer.
- Overflow: PUSH_REQ=1 with FULL_o=1 drops the push, leaves the pointer unchanged and sets OVF_o. This holds even if a pop occurs in the same cycle.
- Pop enable: POP = ~EMPTY_o & ~FLUSH_i & (BLANK_i | ~C_GATE_BLANK).
- Output register:
  - When POP, the head entry goes to VRAM_WAs_o/VRAM_WDs_o and VRAM_WE_o <= 1 at the same edge.
  - Otherwise VRAM_WE_o <= 0; address and data hold their last value.
  - Throughput is one write per cycle.
- Latency: a strobe rise sampled at edge k pushes at edge k. With the gate open, VRAM_WE_o is 1 for the cycle after edge k+1.
- Level: push only → +1; pop only → −1; push and pop together → unchanged.
- FULL_o and EMPTY_o are registered and consistent with FIFO_LEVELs_o every cycle.
- BLANK_i falling: no pop from the next evaluated edge. An entry already popped still completes its VRAM_WE_o cycle.
- FLUSH_i=1:
  - Read/write pointers reset, level=0, OVF_o cleared.
  - VRAM_WE_o <= 0; pushes in that cycle are dropped without setting OVF.
- Reset mid-drain aborts immediately. All FIFO contents are discarded and nothing is written after the reset edge.
- FIFO storage has no reset requirement (inferable as RAM). Read/write pointers are mod C_FIFO_DEPTH.

Test Plan:
- Reset release with REG_WR_STB_i held 1 → no push, EMPTY_o=1. Then 0→1 with BLANK_i=1, ptr=0, WD=0x41 → VRAM_WE_o=1 one cycle, WAs=0, WDs=0x41, two edges after the strobe.
- LD ptr=0x3FE, AUTO_INC=1, three strobes with data 1,2,3 → writes to 0x3FE, 0x3FF, 0x000; ADDR_PTRs_o=0x001.
- C_GATE_BLANK=1, BLANK_i=0, 16 strobes → level=16, FULL_o=1, no VRAM_WE_o. 17th strobe → OVF_o=1, level stays 16. BLANK_i=1 → 16 consecutive WE cycles in order, then EMPTY_o=1.
- BLANK_i toggled 1→0 after 5 pops of 10 queued entries → exactly 5 writes, level=5. Re-open blank → the remaining 5 writes, addresses in order.
- Strobe rise in the same cycle as a pop, with level=4 → level stays 4. Strobe with LD=1 (addr 0x100) → entry address 0x100, ptr=0x101.
- FLUSH_i with level=8 and OVF_o=1 → level=0, OVF_o=0, no further writes, pointer unchanged. Reset asserted mid-drain → VRAM_WE_o=0 from the next edge and all outputs at reset values.

Source files
------------

// File: rtl/osd_vram_wr_bridge.sv
// osd_vram_wr_bridge: CPU strobe -> FIFO -> VRAM write port bridge.
// CPU write strobes are edge-detected, tagged with the current (or freshly
// loaded) address pointer and queued. Entries drain one per cycle to the
// VRAM write port, optionally only while the display is blanked.
module osd_vram_wr_bridge #(
  parameter int C_AW         = 10,
  parameter int C_DW         = 8,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_GATE_BLANK = 1
) (
  input  logic                                CK_i,
  input  logic                                XSYS_R_i,
  input  logic                                REG_ADDR_LD_i,
  input  logic [C_AW-1:0]                     REG_ADDRs_i,
  input  logic [C_DW-1:0]                     REG_WDs_i,
  input  logic                                REG_WR_STB_i,
  input  logic                                REG_AUTO_INC_i,
  input  logic                                BLANK_i,
  input  logic                                FLUSH_i,
  output logic                                VRAM_WE_o,
  output logic [C_AW-1:0]                     VRAM_WAs_o,
  output logic [C_DW-1:0]                     VRAM_WDs_o,
  output logic [C_AW-1:0]                     ADDR_PTRs_o,
  output logic [$clog2(C_FIFO_DEPTH):0]       FIFO_LEVELs_o,
  output logic                                FULL_o,
  output logic                                EMPTY_o,
  output logic                                OVF_o
);

  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = C_AW + C_DW;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(C_FIFO_DEPTH);
  localparam logic [C_AW-1:0] ADR_ONE = C_AW'(1);

  // FIFO storage has no reset so it can map onto RAM
  logic [EW-1:0] mem [C_FIFO_DEPTH];

  logic            stb_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   wr_ptr_n, rd_ptr_n;
  logic [LW-1:0]   level_n;
  logic [C_AW-1:0] ptr_n;
  logic [C_AW-1:0] entry_addr;
  logic            ovf_n;
  logic            push_req, push, pop, gate_open, inc;
  logic [EW-1:0]   head;

  assign gate_open  = (C_GATE_BLANK != 0) ? BLANK_i : 1'b1;
  assign push_req   = REG_WR_STB_i & ~stb_d;
  assign push       = push_req & ~FULL_o & ~FLUSH_i;
  assign pop        = ~EMPTY_o & ~FLUSH_i & gate_open;
  assign inc        = push & REG_AUTO_INC_i;
  assign entry_addr = REG_ADDR_LD_i ? REG_ADDRs_i : ADDR_PTRs_o;
  assign head       = mem[rd_ptr];

  // Next-state logic for pointers, level and overflow flag
  always_comb begin
    ptr_n    = ADDR_PTRs_o;
    level_n  = FIFO_LEVELs_o;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    ovf_n    = OVF_o;

    if (REG_ADDR_LD_i) begin
      ptr_n = REG_ADDRs_i + C_AW'(inc);
    end else if (inc) begin
      ptr_n = ADDR_PTRs_o + ADR_ONE;
    end else begin
      ptr_n = ADDR_PTRs_o;
    end

    if (FLUSH_i) begin
      level_n  = {LW{1'b0}};
      wr_ptr_n = {PW{1'b0}};
      rd_ptr_n = {PW{1'b0}};
      ovf_n    = 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   level_n = FIFO_LEVELs_o + LVL_ONE;
        2'b01:   level_n = FIFO_LEVELs_o - LVL_ONE;
        default: level_n = FIFO_LEVELs_o;
      endcase
      wr_ptr_n = push ? (wr_ptr + PTR_ONE) : wr_ptr;
      rd_ptr_n = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
      ovf_n    = OVF_o | (push_req & FULL_o);
    end
  end

  // Write accepted entries into FIFO storage
  always_ff @(posedge CK_i) begin
    if (push) begin
      mem[wr_ptr] <= {entry_addr, REG_WDs_i};
    end
  end

  // Control/status registers and VRAM output port
  always_ff @(posedge CK_i) begin
    if (!XSYS_R_i) begin
      stb_d         <= 1'b1;   // held-high strobe across reset must not push
      wr_ptr        <= {PW{1'b0}};
      rd_ptr        <= {PW{1'b0}};
      FIFO_LEVELs_o <= {LW{1'b0}};
      FULL_o        <= 1'b0;
      EMPTY_o       <= 1'b1;
      OVF_o         <= 1'b0;
      ADDR_PTRs_o   <= {C_AW{1'b0}};
      VRAM_WE_o     <= 1'b0;
      VRAM_WAs_o    <= {C_AW{1'b0}};
      VRAM_WDs_o    <= {C_DW{1'b0}};
    end else begin
      stb_d         <= REG_WR_STB_i;
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      FIFO_LEVELs_o <= level_n;
      FULL_o        <= (level_n == LVL_FULL);
      EMPTY_o       <= (level_n == {LW{1'b0}});
      OVF_o         <= ovf_n;
      ADDR_PTRs_o   <= ptr_n;
      VRAM_WE_o     <= pop;
      if (pop) begin
        VRAM_WAs_o <= head[EW-1:C_DW];
        VRAM_WDs_o <= head[C_DW-1:0];
      end else begin
        VRAM_WAs_o <= VRAM_WAs_o;
        VRAM_WDs_o <= VRAM_WDs_o;
      end
    end
  end

endmodule

// File: tb/tb_osd_vram_wr_bridge.sv
// Directed testbench for osd_vram_wr_bridge (default parameters).
module tb_osd_vram_wr_bridge;

  logic        ck = 1'b0;
  logic        xsys_r;
  logic        ld;
  logic [9:0]  addrs;
  logic [7:0]  wds;
  logic        stb;
  logic        auto_inc;
  logic        blank;
  logic        flush;
  logic        we;
  logic [9:0]  was;
  logic [7:0]  wdo;
  logic [9:0]  ptr;
  logic [4:0]  level;
  logic        full, empty, ovf;

  int checks = 0;
  int failures = 0;
  logic [17:0] wlog [$];

  osd_vram_wr_bridge dut (
    .CK_i(ck), .XSYS_R_i(xsys_r), .REG_ADDR_LD_i(ld), .REG_ADDRs_i(addrs),
    .REG_WDs_i(wds), .REG_WR_STB_i(stb), .REG_AUTO_INC_i(auto_inc),
    .BLANK_i(blank), .FLUSH_i(flush), .VRAM_WE_o(we), .VRAM_WAs_o(was),
    .VRAM_WDs_o(wdo), .ADDR_PTRs_o(ptr), .FIFO_LEVELs_o(level),
    .FULL_o(full), .EMPTY_o(empty), .OVF_o(ovf)
  );

  always #5 ck = ~ck;

  // one clock edge; outputs sampled 1 time unit later, writes logged
  task automatic step();
    @(posedge ck);
    #1;
    if (we === 1'b1) wlog.push_back({was, wdo});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one CPU write: strobe high for one cycle, then low for one cycle
  task automatic strobe(input logic [7:0] d);
    wds = d; stb = 1'b1;
    step();
    stb = 1'b0;
    step();
  endtask

  initial begin
    xsys_r = 1'b0; ld = 1'b0; addrs = 10'h000; wds = 8'h00; stb = 1'b1;
    auto_inc = 1'b0; blank = 1'b0; flush = 1'b0;
    step(); step();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(was), 32'd0);
    chk("rst_wd", 32'(wdo), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // release reset with strobe still high: no push
    xsys_r = 1'b1;
    step(); step();
    chk("held_stb_level", 32'(level), 32'd0);
    chk("held_stb_empty", 32'(empty), 32'd1);

    // single write, gate open
    stb = 1'b0; step();
    blank = 1'b1; wds = 8'h41; stb = 1'b1;
    step();
    chk("t1_level_after_push", 32'(level), 32'd1);
    chk("t1_we_not_yet", 32'(we), 32'd0);
    step();
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_wa", 32'(was), 32'd0);
    chk("t1_wd", 32'(wdo), 32'h41);
    stb = 1'b0;
    step();
    chk("t1_we_one_cycle", 32'(we), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // pointer wrap with auto-increment
    auto_inc = 1'b1; ld = 1'b1; addrs = 10'h3FE;
    step();
    ld = 1'b0;
    chk("t2_ld_ptr", 32'(ptr), 32'h3FE);
    strobe(8'h01);
    chk("t2_w0", 32'({we, was, wdo}), 32'({1'b1, 10'h3FE, 8'h01}));
    strobe(8'h02);
    chk("t2_w1", 32'({we, was, wdo}), 32'({1'b1, 10'h3FF, 8'h02}));
    strobe(8'h03);
    chk("t2_w2", 32'({we, was, wdo}), 32'({1'b1, 10'h000, 8'h03}));
    chk("t2_ptr", 32'(ptr), 32'h001);

    // fill while blanking closed, then overflow
    blank = 1'b0;
    wlog.delete();
    for (int i = 0; i < 16; i++) strobe(8'(8'h10 + i));
    chk("t3_level16", 32'(level), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_no_writes", 32'(wlog.size()), 32'd0);
    chk("t3_ptr", 32'(ptr), 32'h011);
    strobe(8'hEE);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_level_stays", 32'(level), 32'd16);
    chk("t3_ptr_hold_ovf", 32'(ptr), 32'h011);
    blank = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("t3_drain_count", 32'(wlog.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < wlog.size())
        chk("t3_drain_entry", 32'(wlog[i]), 32'({10'(1 + i), 8'(8'h10 + i)}));
    chk("t3_empty", 32'(empty), 32'd1);
    step();
    chk("t3_we_off", 32'(we), 32'd0);

    // blank closes mid-drain
    blank = 1'b0;
    for (int i = 0; i < 10; i++) strobe(8'(8'h20 + i));
    wlog.delete();
    blank = 1'b1;
    for (int i = 0; i < 5; i++) step();
    blank = 1'b0;
    step(); step(); step();
    chk("t4_five_writes", 32'(wlog.size()), 32'd5);
    chk("t4_level5", 32'(level), 32'd5);
    blank = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_ten_writes", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < wlog.size())
        chk("t4_order", 32'(wlog[i]), 32'({10'(10'h011 + i), 8'(8'h20 + i)}));

    // push and pop in the same cycle
    blank = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'(8'h30 + i));
    chk("t5_level4", 32'(level), 32'd4);
    blank = 1'b1; wds = 8'h34; stb = 1'b1;
    step();
    blank = 1'b0; stb = 1'b0;
    chk("t5_push_pop_level", 32'(level), 32'd4);
    step();
    ld = 1'b1; addrs = 10'h100; wds = 8'h55; stb = 1'b1;
    step();
    ld = 1'b0; stb = 1'b0;
    step();
    chk("t5_ld_ptr", 32'(ptr), 32'h101);
    wlog.delete();
    blank = 1'b1;
    for (int i = 0; i < 5; i++) step();
    blank = 1'b0;
    chk("t5_drain_count", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      chk("t5_first", 32'(wlog[0]), 32'({10'h01C, 8'h31}));
      chk("t5_pp_entry", 32'(wlog[3]), 32'({10'h01F, 8'h34}));
      chk("t5_ld_entry", 32'(wlog[4]), 32'({10'h100, 8'h55}));
    end

    // flush with level 8 and overflow still set
    for (int i = 0; i < 8; i++) strobe(8'(8'h60 + i));
    chk("t6_level8", 32'(level), 32'd8);
    chk("t6_ovf_sticky", 32'(ovf), 32'd1);
    wlog.delete();
    flush = 1'b1; blank = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_level", 32'(level), 32'd0);
    chk("t6_flush_ovf", 32'(ovf), 32'd0);
    chk("t6_flush_empty", 32'(empty), 32'd1);
    step(); step();
    chk("t6_no_writes", 32'(wlog.size()), 32'd0);
    chk("t6_ptr_kept", 32'(ptr), 32'h109);

    // reset in the middle of a drain
    blank = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'(8'h70 + i));
    blank = 1'b1;
    step();
    chk("t7_draining", 32'(we), 32'd1);
    xsys_r = 1'b0;
    step();
    chk("t7_rst_we", 32'(we), 32'd0);
    chk("t7_rst_level", 32'(level), 32'd0);
    chk("t7_rst_empty", 32'(empty), 32'd1);
    chk("t7_rst_ptr", 32'(ptr), 32'd0);
    chk("t7_rst_wa", 32'(was), 32'd0);
    chk("t7_rst_wd", 32'(wdo), 32'd0);
    xsys_r = 1'b1;
    wlog.delete();
    step(); step(); step();
    chk("t7_no_writes_after", 32'(wlog.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
